// File: rtl/keypad_entry_controller_pkg.sv
// Shared types and constants for the 4x4 keypad entry controller.
// Latency: n/a (package: state enum, row idle pattern, key map, edit key codes, row helpers).
// Backpressure: n/a.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  localparam logic [3:0] ROW_IDLE  = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] KEY_NEG   = 4'hE;

  // Indexed by {row, col}. Element 15 is listed first, so read right to left:
  // r0: 1 2 3 A, r1: 4 5 6 B, r2: 7 8 9 C, r3: 0 F E D.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // A usable sample has exactly one active-low row bit asserted.
  function automatic logic row_single_low(input logic [3:0] r);
    return $onehot(~r);
  endfunction

  function automatic logic [1:0] row_low_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_controller_if.sv
// Keypad pins plus entry outputs as one bundle.
// Latency: n/a (wires only). Ports: col (active-low drive), row (active-low sense),
// num (entry register), key_code, key_valid. Backpressure: none; master = controller.
interface keypad_entry_controller_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] num;
  logic [3:0]  key_code;
  logic        key_valid;

  modport master (output col, num, key_code, key_valid, input row);
  modport slave  (input col, num, key_code, key_valid, output row);
endinterface

// File: rtl/keypad_entry_controller_scan_tick_gen.sv
// Column dwell timer: one-cycle tick_o on the last cycle of every SCAN_CNT-cycle dwell.
// Latency: first tick SCAN_CNT-1 cycles after reset release. Ports: clk, rst (async active-low), tick_o.
// Backpressure: none, free running.
module scan_tick_gen #(
  parameter int unsigned SCAN_CNT = 45000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int unsigned TW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam logic [TW-1:0] LAST = TW'(SCAN_CNT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/keypad_entry_controller.sv
// Scans a 4x4 active-low keypad, debounces, decodes to hex and shifts keys into a 16-bit entry.
// Latency: key_valid one cycle after the tick ending dwell k+DEBOUNCE_SCANS (press first seen in dwell k).
// Backpressure: none; ports clk, rst (async active-low), kp (col/row/num/key_code/key_valid).
// Optional KEYPAD_EDIT_KEYS_EN: key F clears num, key E negates num; neither shifts in.
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CNT       = 45000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input logic                         clk,
  input logic                         rst,
  keypad_entry_controller_if.master   kp
);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS);

  logic tick;

  scan_tick_gen #(.SCAN_CNT(SCAN_CNT)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Rows are asynchronous to clk; idle-high reset keeps the first samples "no key".
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= ROW_IDLE;
      row_sync_q <= ROW_IDLE;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
    end
  end

  kp_state_e   state_q, state_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic [15:0] num_q, num_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;

  logic          sample_ok;
  logic [1:0]    sample_row;
  logic [CW-1:0] match_inc, rel_inc;
  logic [3:0]    new_code;
  logic          accept;

  assign sample_ok  = row_single_low(row_sync_q);
  assign sample_row = row_low_index(row_sync_q);
  assign match_inc  = match_cnt_q + 1'b1;
  assign rel_inc    = rel_cnt_q + 1'b1;
  // Column is still held at the pressed key when the press is accepted.
  assign new_code   = KEY_MAP[{row_idx_q, col_idx_q}];

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    match_cnt_d = match_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    num_d       = num_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;

    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (sample_ok) begin
            row_idx_d   = sample_row;
            match_cnt_d = '0;
            state_d     = PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        PRESS_DB: begin
          if (sample_ok && (sample_row == row_idx_q)) begin
            match_cnt_d = match_inc;
            if (match_inc == DB_LAST) begin
              accept    = 1'b1;
              rel_cnt_d = '0;
              state_d   = HELD;
            end
          end else begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          // Any low row, even a chord, counts as still pressed.
          if (row_sync_q == ROW_IDLE) begin
            rel_cnt_d = rel_inc;
            if (rel_inc == DB_LAST) begin
              rel_cnt_d = '0;
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    if (accept) begin
      key_code_d  = new_code;
      key_valid_d = 1'b1;
`ifdef KEYPAD_EDIT_KEYS_EN
      if (new_code == KEY_CLEAR)    num_d = '0;
      else if (new_code == KEY_NEG) num_d = ~num_q + 16'd1;
      else                          num_d = {num_q[11:0], new_code};
`else
      num_d = {num_q[11:0], new_code};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      match_cnt_q <= '0;
      rel_cnt_q   <= '0;
      num_q       <= 16'h0000;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      match_cnt_q <= match_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      num_q       <= num_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.num       = num_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// Bench for keypad_entry_controller with SCAN_CNT=4, DEBOUNCE_SCANS=2.
// Models the keypad matrix as switches between column drive and row sense.
// Build with KEYPAD_EDIT_KEYS_EN defined to exercise the edit keys.
module tb_keypad_entry_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_entry_controller_if kif();

  keypad_entry_controller #(.SCAN_CNT(4), .DEBOUNCE_SCANS(2)) dut (
    .clk (clk),
    .rst (rst_n),
    .kp  (kif)
  );

  // pressed[r][c]: switch closed between row r and column c.
  logic [3:0] pressed [4];
  logic [3:0] row_drv;
  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) row_drv[r] = ~|(pressed[r] & ~kif.col);
  end
  assign kif.row = row_drv;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always @(negedge clk) if (kif.key_valid === 1'b1) pulses++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Returns at the first negedge on which column c has just become driven.
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] want;
    logic [3:0] prev;
    want = ~(4'b0001 << c);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      prev = kif.col;
      @(negedge clk);
      if (kif.col == want && prev != want) ok = 1'b1;
    end
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code,
                           input logic [15:0] exp_num, input string name);
    int p0;
    bit seen;
    p0 = pulses;
    seen = 1'b0;
    pressed[r][c] = 1'b1;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) seen = 1'b1;
    end
    chk({name, " pulse seen"}, 16'(seen), 16'd1);
    if (seen) begin
      chk({name, " key_code"}, 16'(kif.key_code), 16'(code));
      chk({name, " num"}, kif.num, exp_num);
      @(negedge clk);
      chk({name, " pulse width"}, 16'(kif.key_valid), 16'd0);
    end
    repeat (40) @(negedge clk);
    pressed[r][c] = 1'b0;
    repeat (30) @(negedge clk);
    chk({name, " pulse count"}, 16'(pulses - p0), 16'd1);
    chk({name, " num stable"}, kif.num, exp_num);
  endtask

  typedef struct {
    int          r;
    int          c;
    logic [3:0]  code;
    logic [15:0] num;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int p0;
    int lat;
    int col_changes;
    logic [3:0] exp_col;
    logic [3:0] prev_col;

    // Starts from num=16'h0069 (after the 6 and bounced 9 sequences).
    vecs.push_back('{0, 0, 4'h1, 16'h0691});
    vecs.push_back('{0, 3, 4'hA, 16'h691A});
    vecs.push_back('{0, 1, 4'h2, 16'h91A2});
    vecs.push_back('{0, 2, 4'h3, 16'h1A23});
    vecs.push_back('{1, 0, 4'h4, 16'hA234});
`ifdef KEYPAD_EDIT_KEYS_EN
    vecs.push_back('{3, 0, 4'h0, 16'h2340});
    vecs.push_back('{3, 0, 4'h0, 16'h3400});
    vecs.push_back('{3, 0, 4'h0, 16'h4000});
    vecs.push_back('{1, 1, 4'h5, 16'h0005});
    vecs.push_back('{3, 2, 4'hE, 16'hFFFB});
    vecs.push_back('{3, 1, 4'hF, 16'h0000});
    vecs.push_back('{2, 1, 4'h8, 16'h0008});
    vecs.push_back('{3, 0, 4'h0, 16'h0080});
    vecs.push_back('{3, 0, 4'h0, 16'h0800});
    vecs.push_back('{3, 0, 4'h0, 16'h8000});
    vecs.push_back('{3, 2, 4'hE, 16'h8000});
    vecs.push_back('{3, 3, 4'hD, 16'h000D});
`else
    vecs.push_back('{3, 1, 4'hF, 16'h234F});
    vecs.push_back('{3, 2, 4'hE, 16'h34FE});
    vecs.push_back('{3, 3, 4'hD, 16'h4FED});
    vecs.push_back('{3, 0, 4'h0, 16'hFED0});
    vecs.push_back('{2, 0, 4'h7, 16'hED07});
    vecs.push_back('{2, 2, 4'h9, 16'hD079});
    vecs.push_back('{2, 3, 4'hC, 16'h079C});
    vecs.push_back('{1, 3, 4'hB, 16'h79CB});
    vecs.push_back('{1, 1, 4'h5, 16'h9CB5});
    vecs.push_back('{2, 1, 4'h8, 16'hCB58});
    vecs.push_back('{1, 2, 4'h6, 16'hB586});
`endif

    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset col", 16'(kif.col), 16'h000E);
    chk("reset num", kif.num, 16'h0000);
    chk("reset key_code", 16'(kif.key_code), 16'h0000);
    chk("reset key_valid", 16'(kif.key_valid), 16'h0000);

    // Idle scan: column advances every 4 cycles, first move after posedge 4.
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((n / 4) % 4));
      chk("idle col scan", 16'(kif.col), 16'(exp_col));
    end
    chk("idle no pulse", 16'(pulses), 16'd0);
    chk("idle num", kif.num, 16'h0000);

    // Key 6 pressed right as col2 starts: tick ends this dwell at +3, accept at +11, pulse at +12.
    wait_col(2, ok);
    chk("reach col2", 16'(ok), 16'd1);
    p0 = pulses;
    pressed[1][2] = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    chk("key6 latency", 16'(lat), 16'd12);
    chk("key6 key_code", 16'(kif.key_code), 16'h0006);
    chk("key6 num", kif.num, 16'h0006);
    // Chord on the held column while holding 6: must not re-trigger.
    repeat (20) @(negedge clk);
    pressed[0][2] = 1'b1;
    repeat (20) @(negedge clk);
    chk("key6 held col", 16'(kif.col), 16'h000B);
    pressed[0][2] = 1'b0;
    repeat (20) @(negedge clk);
    chk("key6 no repeat while held", 16'(pulses - p0), 16'd1);
    pressed[1][2] = 1'b0;
    repeat (30) @(negedge clk);
    chk("key6 single pulse", 16'(pulses - p0), 16'd1);
    chk("key6 num stable", kif.num, 16'h0006);

    // Bounce on key 9: alternate pressed/released each dwell, then hold steady.
    wait_col(2, ok);
    chk("bounce reach col2", 16'(ok), 16'd1);
    p0 = pulses;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) chk("bounce mismatch advances col", 16'(kif.col), 16'h0007);
      pressed[2][2] = (j % 2 == 0);
      repeat (4) @(negedge clk);
    end
    chk("bounce no pulse", 16'(pulses - p0), 16'd0);
    press_key(2, 2, 4'h9, 16'h0069, "bounce then stable 9");

    // Two rows low on one column: no key, scanning continues.
    p0 = pulses;
    pressed[0][1] = 1'b1;
    pressed[2][1] = 1'b1;
    col_changes = 0;
    for (int i = 0; i < 64; i++) begin
      prev_col = kif.col;
      @(negedge clk);
      if (kif.col != prev_col) col_changes++;
    end
    pressed[0][1] = 1'b0;
    pressed[2][1] = 1'b0;
    repeat (20) @(negedge clk);
    chk("chord no pulse", 16'(pulses - p0), 16'd0);
    chk("chord scan continues", 16'(col_changes >= 14), 16'd1);
    chk("chord num", kif.num, 16'h0069);

    p0 = pulses;
    foreach (vecs[i]) begin
      press_key(vecs[i].r, vecs[i].c, vecs[i].code, vecs[i].num, $sformatf("vec%0d", i));
      if (i == 4) chk("five key sequence pulses", 16'(pulses - p0), 16'd5);
    end

    // Reset while in PRESS_DB: outputs go straight to reset values, no pulse.
    wait_col(1, ok);
    chk("rst reach col1", 16'(ok), 16'd1);
    p0 = pulses;
    pressed[1][1] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-debounce reset col", 16'(kif.col), 16'h000E);
    chk("mid-debounce reset num", kif.num, 16'h0000);
    chk("mid-debounce reset key_code", 16'(kif.key_code), 16'h0000);
    chk("mid-debounce reset key_valid", 16'(kif.key_valid), 16'h0000);
    repeat (3) @(negedge clk);
    pressed[1][1] = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid-debounce reset no pulse", 16'(pulses - p0), 16'd0);
    chk("mid-debounce reset num held", kif.num, 16'h0000);
    press_key(0, 0, 4'h1, 16'h0001, "after reset key1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_controller.md
# keypad_entry_controller

Scans a 4x4 matrix keypad (Pmod KYPD) by column multiplexing, debounces presses, decodes each key to a hex nibble and shifts it into a 16-bit entry register. Its `num` output feeds `hex_display_controller` `num` directly, so typed values appear on the seven-segment display. Single clock domain, no derived clocks: the scan rate comes from an internal enable tick.

## Interface
- `SCAN_CNT`, 45000: clock cycles per column dwell; must be ≥2.
- `DEBOUNCE_SCANS`, 4: consecutive matching dwells needed to accept a press or a release; must be ≥1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `col` out 4: column drive, active-low; exactly one bit low at all times.
- `row` in 4: row sense, active-low, externally pulled up; asynchronous to `clk`.
- `num` out 16: entry register.
- `key_code` out 4: hex value of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a key is accepted.

## Operation
- Reset values: `col`=4'b1110, `num`=16'h0000, `key_code`=4'h0, `key_valid`=0, state SCAN, all counters 0.
- `row` passes through a 2-flop synchronizer before any use.
- Dwell tick: one-cycle pulse every `SCAN_CNT` cycles. The synchronized row is sampled only on the tick, which is the last cycle of the dwell.
- Valid sample: exactly one row bit low. Zero bits or more than one bit low counts as "no key".
- Key map, (row,col) → code: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D. Col 0 is the leftmost.
- FSM states:
  - SCAN: on a tick with no key, advance `col` (0→1→2→3→0, wrapping). On a tick with a valid sample, latch the row index, hold the column, clear the match counter, go to PRESS_DB.
  - PRESS_DB: on each tick, if the sample equals the latched row, increment the match counter. On reaching `DEBOUNCE_SCANS`, accept the key and go to HELD. On any mismatch, return to SCAN and advance the column.
  - HELD: column stays held. Each tick with the row all-high increments the release counter; any tick with a key pressed clears it. When the counter reaches `DEBOUNCE_SCANS`, go to SCAN and advance the column.
- Accept action:
  - `key_code` ← mapped code.
  - `key_valid`=1 for one cycle.
  - `num` ← {num[11:0], key_code}. The top nibble is discarded.
- Held or chorded keys never re-trigger. A second key pressed while in HELD is ignored until a full release.
- Reset mid-debounce or mid-hold: immediate return to reset values. No pulse is emitted.

## Timing
- `col` changes only in the cycle after a tick.
- Press-to-pulse latency, for a stable press seen first in dwell k: pulse occurs 1 cycle after the tick ending dwell k+`DEBOUNCE_SCANS`.
- Synchronizer latency is 2 cycles. Row edges within 2 cycles of a tick may be seen on the following dwell.
- `num` and `key_code` update in the same cycle that `key_valid` is high, and are stable otherwise.

## Configuration
- `KEYPAD_EDIT_KEYS_EN` defined:
  - Key F clears `num` to 0.
  - Key E replaces `num` with its two's complement (~num+1); 16'h8000 is unchanged.
  - Neither key shifts in. `key_valid` still pulses, with `key_code` F or E.
- `KEYPAD_EDIT_KEYS_EN` undefined: all 16 keys shift in identically.

## Structure
- `keypad_pkg` holds:
  - state enum (SCAN, PRESS_DB, HELD)
  - `ROW_IDLE`=4'hF
  - the 16-entry key map constant
  - `KEY_CLEAR`=4'hF and `KEY_NEG`=4'hE
- Sub-module `scan_tick_gen`: `SCAN_CNT` counter producing the enable pulse, cleared by `rst`. All remaining logic lives in the top module.

## Test plan
Benches use `SCAN_CNT`=4 and `DEBOUNCE_SCANS`=2.
- Reset, no keys → `col` cycles 1110→1101→1011→0111→1110 every 4 cycles; `num`=0; no `key_valid`.
- Hold row1 low while col2 is driven, then release → single pulse with `key_code`=6 and `num`=16'h0006; no repeat while held.
- Press 1, A, 2, 3, 4 in sequence, each released → `num` ends at 16'hA234 (leading 1 shifted out); exactly 5 pulses.
- Bounce: row toggles on alternating dwells before going stable → pulse only after 2 consecutive matching dwells; no pulse on bounce alone.
- Two rows low at once on the same column → treated as no key; scan continues; no pulse.
- With `KEYPAD_EDIT_KEYS_EN`: enter 0,0,0,5 then E → `num`=16'hFFFB; then F → `num`=0. Also assert `rst` during PRESS_DB → outputs return to reset values and no pulse.
